// File: rtl/micro_debug_ctrl_if.sv
// ---------------------------------------------------------------------------
// micro_debug_ctrl_if
// Host command/response channel between a debug bridge (UART/JTAG) and the
// micro_debug_ctrl run-control sequencer.
//
// Signals:
//   cmd_valid  host -> ctrl  command valid
//   cmd_ready  ctrl -> host  command accepted when cmd_valid && cmd_ready
//   cmd_op     host -> ctrl  opcode (STATUS/HALT/RUN/STEP/SETBP/MEM_RD/MEM_WR/W_RD)
//   cmd_addr   host -> ctrl  address for SETBP / MEM_RD / MEM_WR
//   cmd_data   host -> ctrl  step count, breakpoint enable (bit 0) or write data
//   rsp_valid  ctrl -> host  one-cycle response pulse, always accepted
//   rsp_data   ctrl -> host  response payload
//   rsp_err    ctrl -> host  command rejected
// Modports: master = host side, slave = controller side.
// ---------------------------------------------------------------------------
interface micro_debug_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/micro_debug_ctrl.sv
// ---------------------------------------------------------------------------
// micro_debug_ctrl
// Run-control and debug-access sequencer for the 8-bit single-cycle core.
// Gates instruction commit through core_en_o (halt / run / N-step / one PC
// breakpoint) and, while halted, owns the data-memory port for host access.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   host                command/response channel (slave modport)
//   core_en_o           core commits its current instruction on this edge
//   core_pc_i/core_w_i  core program counter / working register
//   dbg_mem_sel_o       memory port owned by debug (core stores blocked)
//   dbg_mem_addr_o      debug memory address
//   dbg_mem_we_o        debug synchronous write strobe
//   dbg_mem_wdata_o     debug write data
//   dbg_mem_rdata_i     asynchronous memory read data
//   halted_o            controller is in HALTED
//   bp_hit_o            last halt was caused by the breakpoint
// ---------------------------------------------------------------------------
module micro_debug_ctrl #(
    parameter int DW           = 8,
    parameter int AW           = 8,
    parameter bit RESET_HALTED = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    micro_debug_ctrl_if.slave host,
    output logic          core_en_o,
    input  logic [DW-1:0] core_pc_i,
    input  logic [DW-1:0] core_w_i,
    output logic          dbg_mem_sel_o,
    output logic [AW-1:0] dbg_mem_addr_o,
    output logic          dbg_mem_we_o,
    output logic [DW-1:0] dbg_mem_wdata_o,
    input  logic [DW-1:0] dbg_mem_rdata_i,
    output logic          halted_o,
    output logic          bp_hit_o
);
    localparam logic [2:0] OP_STATUS = 3'd0;
    localparam logic [2:0] OP_HALT   = 3'd1;
    localparam logic [2:0] OP_RUN    = 3'd2;
    localparam logic [2:0] OP_STEP   = 3'd3;
    localparam logic [2:0] OP_SETBP  = 3'd4;
    localparam logic [2:0] OP_MEM_RD = 3'd5;
    localparam logic [2:0] OP_MEM_WR = 3'd6;
    localparam logic [2:0] OP_W_RD   = 3'd7;

    typedef enum logic [1:0] {ST_HALTED, ST_RUN, ST_STEP} state_t;

    state_t        state_q, state_d;
    logic          bp_en_q, bp_en_d;
    logic [AW-1:0] bp_addr_q, bp_addr_d;
    logic          bp_hit_q, bp_hit_d;
    logic          skip_q, skip_d;
    logic [DW-1:0] step_cnt_q, step_cnt_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic          step_rsp_q, step_rsp_d;   // response carries the live PC

    logic is_halted;
    logic fire;
    logic bp_stop;
    logic mem_we;

    assign is_halted      = (state_q == ST_HALTED);
    assign host.cmd_ready = (state_q != ST_STEP);
    assign fire           = host.cmd_valid && host.cmd_ready;
    // skip lets a resume from the breakpoint address execute it once
    assign bp_stop        = bp_en_q && (core_pc_i == DW'(bp_addr_q)) && !skip_q;

    always_comb begin
        state_d     = state_q;
        bp_en_d     = bp_en_q;
        bp_addr_d   = bp_addr_q;
        bp_hit_d    = bp_hit_q;
        skip_d      = skip_q;
        step_cnt_d  = step_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        step_rsp_d  = 1'b0;
        core_en_o   = 1'b0;
        mem_we      = 1'b0;

        // Command decode first; the breakpoint stop below must win on bp_hit.
        if (fire) begin
            rsp_valid_d = 1'b1;
            case (host.cmd_op)
                OP_STATUS: rsp_data_d = core_pc_i;
                OP_HALT:   ;
                OP_RUN: begin
                    bp_hit_d = 1'b0;
                    if (is_halted) begin
                        state_d = ST_RUN;
                        skip_d  = 1'b1;
                    end
                end
                OP_STEP: begin
                    if (!is_halted) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        bp_hit_d = 1'b0;
                        if (host.cmd_data != '0) begin
                            state_d     = ST_STEP;
                            step_cnt_d  = host.cmd_data;
                            rsp_valid_d = 1'b0;   // answered when stepping ends
                        end
                    end
                end
                OP_SETBP: begin
                    bp_addr_d = host.cmd_addr;
                    bp_en_d   = host.cmd_data[0];
                end
                OP_MEM_RD: begin
                    if (is_halted) rsp_data_d = dbg_mem_rdata_i;
                    else           rsp_err_d  = 1'b1;
                end
                OP_MEM_WR: begin
                    if (is_halted) mem_we    = 1'b1;
                    else           rsp_err_d = 1'b1;
                end
                OP_W_RD:   rsp_data_d = core_w_i;
                default:   ;
            endcase
        end

        case (state_q)
            ST_HALTED: core_en_o = 1'b0;
            ST_RUN: begin
                core_en_o = !bp_stop && !(fire && host.cmd_op == OP_HALT);
                if (bp_stop) begin
                    state_d  = ST_HALTED;
                    bp_hit_d = 1'b1;
                end else if (fire && host.cmd_op == OP_HALT) begin
                    state_d = ST_HALTED;
                end
            end
            ST_STEP: begin
                core_en_o  = 1'b1;
                step_cnt_d = step_cnt_q - 1'b1;
                if (step_cnt_q == DW'(1)) begin
                    state_d     = ST_HALTED;
                    rsp_valid_d = 1'b1;
                    step_rsp_d  = 1'b1;
                end
            end
            default: state_d = ST_HALTED;
        endcase

        if (core_en_o) skip_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RESET_HALTED ? ST_HALTED : ST_RUN;
            bp_en_q     <= 1'b0;
            bp_addr_q   <= '0;
            bp_hit_q    <= 1'b0;
            skip_q      <= 1'b0;
            step_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            step_rsp_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bp_en_q     <= bp_en_d;
            bp_addr_q   <= bp_addr_d;
            bp_hit_q    <= bp_hit_d;
            skip_q      <= skip_d;
            step_cnt_q  <= step_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            step_rsp_q  <= step_rsp_d;
        end
    end

    // A step response reports the PC after the last committed instruction,
    // which is only visible in the cycle following that commit.
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_data  = step_rsp_q ? core_pc_i : rsp_data_q;
    assign host.rsp_err   = rsp_err_q;

    assign dbg_mem_sel_o   = is_halted;
    assign dbg_mem_addr_o  = host.cmd_addr;
    assign dbg_mem_we_o    = mem_we && !reset;
    assign dbg_mem_wdata_o = host.cmd_data;
    assign halted_o        = is_halted;
    assign bp_hit_o        = bp_hit_q;
endmodule

// File: tb/tb_micro_debug_ctrl.sv
// ---------------------------------------------------------------------------
// tb_micro_debug_ctrl
// Directed + randomized checks of micro_debug_ctrl against a simple core
// model (PC counter with a self-loop at LOOP_PC) and a data memory model.
// Expected values come from run-control rules: instruction counts, PC
// arithmetic and a shadow of the host's memory writes.
// ---------------------------------------------------------------------------
module tb_micro_debug_ctrl;
    localparam logic [7:0] LOOP_PC = 8'h10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    micro_debug_ctrl_if #(.DW(8), .AW(8)) host ();

    logic       core_en, dbg_mem_sel, dbg_mem_we, halted, bp_hit;
    logic [7:0] core_pc, core_w, dbg_mem_addr, dbg_mem_wdata, dbg_mem_rdata;

    micro_debug_ctrl #(.DW(8), .AW(8), .RESET_HALTED(1'b1)) dut (
        .clk             (clk),
        .reset           (reset),
        .host            (host),
        .core_en_o       (core_en),
        .core_pc_i       (core_pc),
        .core_w_i        (core_w),
        .dbg_mem_sel_o   (dbg_mem_sel),
        .dbg_mem_addr_o  (dbg_mem_addr),
        .dbg_mem_we_o    (dbg_mem_we),
        .dbg_mem_wdata_o (dbg_mem_wdata),
        .dbg_mem_rdata_i (dbg_mem_rdata),
        .halted_o        (halted),
        .bp_hit_o        (bp_hit)
    );

    // Mid-cycle samples of DUT outputs, consumed by the models at posedge.
    logic       en_s = 1'b0, we_s = 1'b0;
    logic [7:0] waddr_s = '0, wdata_s = '0;
    int         en_cnt = 0, rsp_cnt = 0, we_bad = 0;

    always @(negedge clk) begin
        en_s    <= core_en;
        we_s    <= dbg_mem_we;
        waddr_s <= dbg_mem_addr;
        wdata_s <= dbg_mem_wdata;
        if (core_en)                 en_cnt  <= en_cnt + 1;
        if (host.rsp_valid)          rsp_cnt <= rsp_cnt + 1;
        if (dbg_mem_we && !halted)   we_bad  <= we_bad + 1;
    end

    // Core model
    logic       load_req = 1'b0;
    logic [7:0] load_val = '0;
    logic [7:0] pc_m, w_m;
    assign core_pc = pc_m;
    assign core_w  = w_m;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_m <= '0;
            w_m  <= '0;
        end else if (load_req) begin
            pc_m <= load_val;
        end else if (en_s) begin
            pc_m <= (pc_m == LOOP_PC) ? pc_m : pc_m + 8'd1;
            w_m  <= w_m + 8'h13;
        end
    end

    // Data memory model
    logic [7:0] mem [256];
    always @(posedge clk) if (we_s) mem[waddr_s] <= wdata_s;
    assign dbg_mem_rdata = mem[dbg_mem_addr];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command from the post-edge phase; return the outputs seen
    // one cycle after the fire.
    task automatic do_cmd(input logic [2:0] op, input logic [7:0] addr, input logic [7:0] data,
                          output logic v, output logic [7:0] d, output logic e);
        int n;
        host.cmd_valid = 1'b1;
        host.cmd_op    = op;
        host.cmd_addr  = addr;
        host.cmd_data  = data;
        n = 0;
        while (!host.cmd_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) chk("ready_timeout", 32'(n), 32'(0));
        @(posedge clk); #1;
        host.cmd_valid = 1'b0;
        v = host.rsp_valid;
        d = host.rsp_data;
        e = host.rsp_err;
    endtask

    task automatic wait_rsp(input int limit, output int n, output int nr);
        n  = 0;
        nr = 0;
        while (!host.rsp_valid && n < limit) begin
            if (!host.cmd_ready) nr++;
            @(posedge clk); #1;
            n++;
        end
        if (n >= limit) chk("rsp_timeout", 32'(n), 32'(0));
    endtask

    task automatic load_pc(input logic [7:0] val);
        load_req = 1'b1;
        load_val = val;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    logic       v, e;
    logic [7:0] d;
    int         e0, r0, n, nr;
    logic [7:0] shadow [int];
    logic [7:0] a, wd, pc0, steps;

    initial begin
        host.cmd_valid = 1'b0;
        host.cmd_op    = '0;
        host.cmd_addr  = '0;
        host.cmd_data  = '0;

        // 1. reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_halted", 32'(halted), 32'(1));
        chk("rst_core_en", 32'(core_en), 32'(0));
        chk("rst_rsp_valid", 32'(host.rsp_valid), 32'(0));
        chk("rst_bp_hit", 32'(bp_hit), 32'(0));
        chk("rst_mem_sel", 32'(dbg_mem_sel), 32'(1));
        reset = 1'b0;
        @(posedge clk); #1;
        do_cmd(3'd0, 8'h00, 8'h00, v, d, e);
        chk("status_valid", 32'(v), 32'(1));
        chk("status_data", 32'(d), 32'h00);
        chk("status_err", 32'(e), 32'(0));

        // 2. breakpoint at 0x04
        do_cmd(3'd4, 8'h04, 8'h01, v, d, e);
        chk("setbp_valid", 32'(v), 32'(1));
        e0 = en_cnt;
        do_cmd(3'd2, 8'h00, 8'h00, v, d, e);
        chk("run_valid", 32'(v), 32'(1));
        n = 0;
        while (!halted && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_halted", 32'(halted), 32'(1));
        chk("bp_en_count", 32'(en_cnt - e0), 32'(4));
        chk("bp_pc", 32'(core_pc), 32'h04);
        chk("bp_hit_set", 32'(bp_hit), 32'(1));
        chk("bp_core_en", 32'(core_en), 32'(0));

        // 3. resume from the breakpoint, run into the self-loop
        do_cmd(3'd2, 8'h00, 8'h00, v, d, e);
        chk("resume_valid", 32'(v), 32'(1));
        chk("resume_bp_hit", 32'(bp_hit), 32'(0));
        repeat (40) @(posedge clk);
        #1;
        chk("loop_running", 32'(halted), 32'(0));
        chk("loop_pc", 32'(core_pc), 32'(LOOP_PC));
        do_cmd(3'd1, 8'h00, 8'h00, v, d, e);
        chk("halt_valid", 32'(v), 32'(1));
        chk("halt_halted", 32'(halted), 32'(1));
        chk("halt_bp_hit", 32'(bp_hit), 32'(0));
        do_cmd(3'd1, 8'h00, 8'h00, v, d, e);
        chk("halt_noop_valid", 32'(v), 32'(1));
        do_cmd(3'd7, 8'h00, 8'h00, v, d, e);
        chk("wrd_data", 32'(d), 32'(w_m));

        // 4. STEP 3 from PC 2, then STEP 0
        load_pc(8'h02);
        e0 = en_cnt;
        do_cmd(3'd3, 8'h00, 8'd3, v, d, e);
        chk("step_no_early_rsp", 32'(v), 32'(0));
        wait_rsp(50, n, nr);
        chk("step_latency", 32'(n), 32'(3));
        chk("step_not_ready", 32'(nr), 32'(3));
        chk("step_rsp_pc", 32'(host.rsp_data), 32'h05);
        chk("step_en_count", 32'(en_cnt - e0), 32'(3));
        chk("step_halted", 32'(halted), 32'(1));
        e0 = en_cnt;
        do_cmd(3'd3, 8'h00, 8'd0, v, d, e);
        chk("step0_valid", 32'(v), 32'(1));
        chk("step0_en", 32'(en_cnt - e0), 32'(0));

        // 5. memory access
        do_cmd(3'd6, 8'h01, 8'h2A, v, d, e);
        chk("memwr_err", 32'(e), 32'(0));
        shadow[1] = 8'h2A;
        do_cmd(3'd5, 8'h01, 8'h00, v, d, e);
        chk("memrd_data", 32'(d), 32'h2A);
        for (int i = 0; i < 8; i++) begin
            a  = 8'($urandom_range(255));
            wd = 8'($urandom_range(255));
            shadow[a] = wd;
            do_cmd(3'd6, a, wd, v, d, e);
        end
        foreach (shadow[k]) begin
            do_cmd(3'd5, 8'(k), 8'h00, v, d, e);
            chk("memrd_rand", 32'(d), 32'(shadow[k]));
        end
        do_cmd(3'd2, 8'h00, 8'h00, v, d, e);
        repeat (3) @(posedge clk);
        #1;
        do_cmd(3'd5, 8'h01, 8'h00, v, d, e);
        chk("memrd_run_err", 32'(e), 32'(1));
        chk("memrd_run_data", 32'(d), 32'(0));
        do_cmd(3'd6, 8'h01, 8'h55, v, d, e);
        chk("memwr_run_err", 32'(e), 32'(1));
        do_cmd(3'd3, 8'h00, 8'd2, v, d, e);
        chk("step_run_err", 32'(e), 32'(1));
        chk("no_we_in_run", 32'(we_bad), 32'(0));
        do_cmd(3'd1, 8'h00, 8'h00, v, d, e);
        do_cmd(3'd5, 8'h01, 8'h00, v, d, e);
        chk("memwr_run_blocked", 32'(d), 32'h2A);

        // randomized steps
        for (int i = 0; i < 5; i++) begin
            pc0   = 8'($urandom_range(32'h80, 32'h20));
            steps = 8'($urandom_range(20, 1));
            load_pc(pc0);
            e0 = en_cnt;
            do_cmd(3'd3, 8'h00, steps, v, d, e);
            wait_rsp(100, n, nr);
            chk("rstep_pc", 32'(host.rsp_data), 32'(pc0 + steps));
            chk("rstep_en", 32'(en_cnt - e0), 32'(steps));
        end

        // 6. HALT fired in the same cycle as the breakpoint
        load_pc(8'h30);
        do_cmd(3'd4, 8'h33, 8'h01, v, d, e);
        do_cmd(3'd2, 8'h00, 8'h00, v, d, e);
        n = 0;
        while (core_pc != 8'h33 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_bp", 32'(core_pc), 32'h33);
        host.cmd_valid = 1'b1;
        host.cmd_op    = 3'd1;
        #2;
        chk("halt_bp_core_en", 32'(core_en), 32'(0));
        @(posedge clk); #1;
        host.cmd_valid = 1'b0;
        chk("halt_bp_rsp", 32'(host.rsp_valid), 32'(1));
        chk("halt_bp_halted", 32'(halted), 32'(1));
        chk("halt_bp_hit", 32'(bp_hit), 32'(1));
        chk("halt_bp_pc", 32'(core_pc), 32'h33);

        // reset in the middle of a long step
        do_cmd(3'd4, 8'h00, 8'h00, v, d, e);
        do_cmd(3'd3, 8'h00, 8'd200, v, d, e);
        r0 = rsp_cnt;
        repeat (10) @(posedge clk);
        #1;
        chk("long_step_busy", 32'(halted), 32'(0));
        reset = 1'b1;
        #1;
        chk("arst_halted", 32'(halted), 32'(1));
        chk("arst_core_en", 32'(core_en), 32'(0));
        chk("arst_rsp", 32'(host.rsp_valid), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (250) @(posedge clk);
        #1;
        chk("arst_no_rsp", 32'(rsp_cnt - r0), 32'(0));
        chk("arst_still_halted", 32'(halted), 32'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
